// File: rtl/gyruss_hpf_1st.sv
// ---------------------------------------------------------------------------
// gyruss_hpf_1st
//   First-order high-pass IIR (DC blocker) for the audio path:
//      y[n] = (B0*x[n] + B1*x[n-1] - A1*y[n-1]) >>> 15
//   One new sample is taken every DIV clocks. One shared 18x18 signed
//   multiplier is stepped through the three products by a small FSM.
//
// Parameters
//   DIV - clk cycles per sample period (must be >= 8)
//   B0  - Q15 coefficient on x[n]
//   B1  - Q15 coefficient on x[n-1]
//   A1  - Q15 feedback coefficient on y[n-1] (denominator 1 + A1*z^-1)
//
// Ports
//   clk       - single clock
//   reset     - synchronous, active-high reset
//   in        - signed 16-bit sample, taken only on the strobe cycle
//   out       - signed 16-bit filter output, held between updates
//   out_valid - one-cycle pulse on the cycle out takes a new value
//
// Build option
//   GYRUSS_HPF_SAT_EN - when defined, the shifted result saturates to
//                       16 bits; otherwise it wraps (low 16 bits kept).
//
// State table
//   IDLE   | wait for strobe; on strobe latch in -> x_cur, clear acc
//   MAC_B0 | acc += B0 * x_cur
//   MAC_B1 | acc += B1 * x_prev
//   MAC_A1 | acc -= A1 * y_prev
//   WRITE  | out, y_prev <= limited result; x_prev <= x_cur; pulse out_valid
// ---------------------------------------------------------------------------
module gyruss_hpf_1st #(
    parameter int                 DIV = 220,
    parameter logic signed [17:0] B0  = 18'sd32754,
    parameter logic signed [17:0] B1  = -18'sd32754,
    parameter logic signed [17:0] A1  = -18'sd32740
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] in,
    output logic signed [15:0] out,
    output logic               out_valid
);

    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        MAC_B0,
        MAC_B1,
        MAC_A1,
        WRITE
    } state_t;

    state_t             state;
    logic [CW-1:0]      counter;
    logic               strobe;
    logic signed [15:0] x_cur;
    logic signed [15:0] x_prev;
    logic signed [15:0] y_prev;
    logic signed [39:0] acc;
    logic signed [17:0] mul_a;
    logic signed [17:0] mul_b;
    logic signed [35:0] product;
    logic signed [39:0] product_ext;
    logic signed [15:0] limited;

    assign strobe = (counter == LAST);

    // Operand select for the shared multiplier; zero outside the MAC states.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            MAC_B0: begin
                mul_a = B0;
                mul_b = {{2{x_cur[15]}}, x_cur};
            end
            MAC_B1: begin
                mul_a = B1;
                mul_b = {{2{x_prev[15]}}, x_prev};
            end
            MAC_A1: begin
                mul_a = A1;
                mul_b = {{2{y_prev[15]}}, y_prev};
            end
            default: ;
        endcase
    end

    assign product     = mul_a * mul_b;
    assign product_ext = {{4{product[35]}}, product};

`ifdef GYRUSS_HPF_SAT_EN
    logic signed [39:0] shifted;

    assign shifted = acc >>> 15;

    always_comb begin
        if (shifted > 40'sd32767)
            limited = 16'sh7FFF;
        else if (shifted < -40'sd32768)
            limited = 16'sh8000;
        else
            limited = shifted[15:0];
    end
`else
    // Low 16 bits of (acc >>> 15): plain two's-complement wrap.
    assign limited = acc[30:15];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            counter   <= '0;
            state     <= IDLE;
            acc       <= '0;
            x_cur     <= '0;
            x_prev    <= '0;
            y_prev    <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            counter   <= strobe ? '0 : counter + CW'(1);
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (strobe) begin
                        x_cur <= in;
                        acc   <= '0;
                        state <= MAC_B0;
                    end
                end
                MAC_B0: begin
                    acc   <= acc + product_ext;
                    state <= MAC_B1;
                end
                MAC_B1: begin
                    acc   <= acc + product_ext;
                    state <= MAC_A1;
                end
                MAC_A1: begin
                    // Feedback term enters with a minus sign (1 + A1*z^-1 form).
                    acc   <= acc - product_ext;
                    state <= WRITE;
                end
                WRITE: begin
                    // y_prev takes the limited value so feedback matches out.
                    out       <= limited;
                    y_prev    <= limited;
                    x_prev    <= x_cur;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
